// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state and frame command encodings for the SPI slave
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: latches a read byte on load and shifts it out MSB-first once
module spi_tx_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         miso,
  output logic         last,
  output logic         done
);
  localparam int CW = $clog2(W);
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          busy;
  assign miso = busy & sr[W-1];
  assign last = busy && cnt == CW'(W - 1);
  // load once per frame, then shift one bit per cycle; done stays set until the frame ends
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load && !busy && !done) begin
      sr   <= din;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sr   <= sr << 1;
      cnt  <= cnt + CW'(1);
      busy <= !last;
      done <= last;
    end
  end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI frame receiver with RAM command decode and read-data serializer
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW);
  state_t        state, nxt;
  logic [FW-1:0] sr;
  logic [CW-1:0] cnt;
  logic          frame_done, rd_addr_seen, tx_load, tx_last, tx_done;
  // read byte is accepted only in READ_DATA after its own rx_valid cycle, once per frame
  assign tx_load = state == READ_DATA && frame_done && !rx_valid && !tx_done && tx_valid && !SS_n;
  // SS_n high always returns to IDLE; the direction bit picks write or the read phase
  always_comb begin
    nxt = SS_n ? IDLE :
          state == IDLE ? CHK_CMD :
          state == CHK_CMD ? (!MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD) :
          state;
  end
  // frame shifter, bit counter, output word and read-address tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      frame_done   <= 1'b0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      state    <= nxt;
      rx_valid <= 1'b0;
      if (SS_n || state == IDLE || state == CHK_CMD) begin
        sr         <= '0;
        cnt        <= '0;
        frame_done <= 1'b0;
      end else if (!frame_done) begin
        sr  <= {sr[FW-2:0], MOSI};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(FW - 1)) begin
          rx_data      <= {sr[FW-2:0], MOSI};
          rx_valid     <= 1'b1;
          frame_done   <= 1'b1;
          rd_addr_seen <= rd_addr_seen | (state == READ_ADD);
        end
      end
      if (tx_last) rd_addr_seen <= 1'b0;
    end
  end
  spi_tx_serializer #(.W(DATA_W)) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (SS_n),
    .load (tx_load),
    .din  (tx_data),
    .miso (MISO),
    .last (tx_last),
    .done (tx_done)
  );
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: DATA_W, default 8, RAM data width; the frame word is DATA_W+2 bits (2-bit command, DATA_W payload).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 SS_n  input  1  SPI slave select, active-low; frame delimiter.
REQ-005 MOSI  input  1  serial data from master, sampled on posedge clk.
REQ-006 MISO  output  1  serial read data to master.
REQ-007 rx_data  output  DATA_W+2  parallel frame to RAM: [9:8] command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-008 rx_valid  output  1  one-cycle strobe; rx_data is valid when high.
REQ-009 tx_data  input  DATA_W  read data from RAM.
REQ-010 tx_valid  input  1  one-cycle strobe from RAM; tx_data is valid when high.

Function
REQ-011 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012 IDLE -> CHK_CMD when SS_n=0; otherwise the FSM stays in IDLE.
REQ-013 CHK_CMD transitions (the MOSI bit sampled here is the direction bit and is not stored):
- SS_n=1 -> IDLE.
- MOSI=0 -> WRITE.
- MOSI=1 with rd_addr_seen=0 -> READ_ADD.
- MOSI=1 with rd_addr_seen=1 -> READ_DATA.
REQ-014 In WRITE, READ_ADD and READ_DATA, the block SHALL shift MOSI MSB-first into a 10-bit shift register, one bit per cycle, and count bits 0..9.
REQ-015 On the cycle after the 10th bit is sampled, rx_data SHALL equal the shifted word and rx_valid SHALL be 1 for exactly one cycle.
- rx_data holds its value until the next frame completes.
REQ-016 READ_ADD SHALL set rd_addr_seen on its rx_valid cycle.
REQ-017 In READ_DATA, after its rx_valid, the block SHALL wait for tx_valid.
- On the tx_valid cycle, tx_data is latched.
- MISO SHALL drive tx_data[7] through tx_data[0] on the following 8 consecutive cycles.
- rd_addr_seen SHALL be cleared after bit 0 is driven.
REQ-018 MISO SHALL be 0 whenever the block is not serializing read data.
REQ-019 After frame completion (and, in READ_DATA, after serialization) the FSM SHALL hold its state with no further rx_valid until SS_n=1, then go to IDLE.
REQ-020 SS_n=1 mid-frame SHALL abort to IDLE on the next edge:
- no rx_valid, counters cleared, MISO=0, rd_addr_seen unchanged.
REQ-021 tx_valid SHALL be ignored outside the READ_DATA wait phase.
- tx_valid arriving in the same cycle as rx_valid SHALL also be ignored.
REQ-022 rx_valid latency SHALL be exactly 11 cycles after the CHK_CMD sample cycle.

Reset
REQ-023 When rst_n=0 at a posedge, the block SHALL reset to:
- state IDLE;
- rx_data=0, rx_valid=0, MISO=0;
- rd_addr_seen=0, bit counters=0, latched tx byte=0.
REQ-024 Reset mid-frame or mid-serialization SHALL discard the partial transfer, with no rx_valid on the cycle after release.

Structure
REQ-025 A shared package spi_pkg SHALL hold:
- the state enum;
- the command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
REQ-026 One sub-module, spi_tx_serializer, SHALL hold the 8-bit load-on-tx_valid, MSB-first shifter and its done flag; everything else stays in spi_slave.

Verification
REQ-027 Write address: SS_n low, MOSI 0 then 10'b00_1010_0101 -> rx_data=10'h0A5 with one rx_valid pulse 11 cycles after CHK_CMD; no MISO activity.
REQ-028 Read sequence:
- Frame 1: MOSI 1, 10'b10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1.
- Frame 2: MOSI 1, 10'b11_0000_0000 -> rx_data=10'h300.
- Then tx_valid with tx_data=8'hC3 -> MISO=1,1,0,0,0,0,1,1 over the next 8 cycles; rd_addr_seen=0 afterwards.
REQ-029 Abort: SS_n raised after 5 payload bits -> no rx_valid, IDLE next cycle; the next complete frame decodes correctly.
REQ-030 Reset: rst_n=0 during MISO bit 3 -> MISO=0, state IDLE, rd_addr_seen=0 on the next edge.
REQ-031 Spurious tx_valid while in WRITE or IDLE -> MISO stays 0 and no state change.
REQ-032 Back-to-back frames 10'h0A5 then 10'h1FF (SS_n toggled high for 1 cycle between them) -> two rx_valid pulses carrying the correct words.
